// File: rtl/writeback_stage.sv
// ============================================================================
// Module   : writeback_stage
// Purpose  : Writeback stage with a 2-entry register-file write FIFO, youngest-
//            write bypass and a retired-instruction counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_stage #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 20,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] instruction,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] address,
    input  logic              rf_ready,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [3:0] c_OP_STORE  = 4'b1100;
    localparam logic [3:0] c_OP_LOAD_A = 4'b1101;
    localparam logic [3:0] c_OP_LOAD_B = 4'b1111;
    localparam logic [1:0] c_DEPTH     = 2'd2;

    logic [1:0]        r_count;
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [ADDR_W-1:0] r_ent_addr [2];
    logic [DATA_W-1:0] r_ent_data [2];
    logic              r_wb_en;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_wb_data;
    logic [ADDR_W-1:0] r_fwd_addr;
    logic [DATA_W-1:0] r_fwd_data;
    logic [CNT_W-1:0]  r_retired;

    logic [3:0]        w_opcode;
    logic              w_is_load;
    logic              w_no_write;
    logic              w_accept;
    logic              w_push;
    logic              w_store_ret;
    logic              w_pop;
    logic [DATA_W-1:0] w_wdata;
    logic [1:0]        w_count_n;
    logic              w_rd_ptr_n;
    logic              w_wr_ptr_n;
    logic [ADDR_W-1:0] w_ent_addr_n [2];
    logic [DATA_W-1:0] w_ent_data_n [2];
    logic [ADDR_W-1:0] w_wb_addr_n;
    logic [DATA_W-1:0] w_wb_data_n;
    logic [ADDR_W-1:0] w_fwd_addr_n;
    logic [DATA_W-1:0] w_fwd_data_n;
    logic [CNT_W-1:0]  w_retired_n;
    logic              w_unused;

    // Only the opcode field of the instruction matters to this stage.
    assign w_unused   = ^instruction[DATA_W-5:0];

    assign w_opcode   = instruction[DATA_W-1 -: 4];
    assign w_is_load  = (w_opcode == c_OP_LOAD_A) || (w_opcode == c_OP_LOAD_B);
    assign w_no_write = (w_opcode == c_OP_STORE) ||
                        ((ZERO_REG == 1) && (address == '0));

    assign ready_in    = (r_count != c_DEPTH);
    assign w_accept    = valid_in && ready_in;
    assign w_push      = w_accept && !w_no_write;
    assign w_store_ret = w_accept && w_no_write;
    assign w_pop       = (r_count != 2'd0) && rf_ready;
    assign w_wdata     = w_is_load ? mem_data : alu_result;

    assign w_count_n   = r_count + {1'b0, w_push} - {1'b0, w_pop};
    assign w_rd_ptr_n  = r_rd_ptr ^ w_pop;
    assign w_wr_ptr_n  = r_wr_ptr ^ w_push;
    assign w_retired_n = r_retired + CNT_W'(w_store_ret) + CNT_W'(w_pop);

    // Outputs are registered, so they are computed from next-cycle FIFO state.
    always_comb begin
        w_ent_addr_n = r_ent_addr;
        w_ent_data_n = r_ent_data;
        w_wb_addr_n  = '0;
        w_wb_data_n  = '0;
        w_fwd_addr_n = '0;
        w_fwd_data_n = '0;
        if (w_push) begin
            w_ent_addr_n[r_wr_ptr] = address;
            w_ent_data_n[r_wr_ptr] = w_wdata;
        end
        if (w_count_n != 2'd0) begin
            w_wb_addr_n  = w_ent_addr_n[w_rd_ptr_n];
            w_wb_data_n  = w_ent_data_n[w_rd_ptr_n];
            w_fwd_addr_n = w_ent_addr_n[~w_wr_ptr_n];
            w_fwd_data_n = w_ent_data_n[~w_wr_ptr_n];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count    <= 2'd0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_fwd_addr <= '0;
            r_fwd_data <= '0;
            r_retired  <= '0;
        end else begin
            r_count    <= w_count_n;
            r_rd_ptr   <= w_rd_ptr_n;
            r_wr_ptr   <= w_wr_ptr_n;
            r_wb_en    <= (w_count_n != 2'd0);
            r_wb_addr  <= w_wb_addr_n;
            r_wb_data  <= w_wb_data_n;
            r_fwd_addr <= w_fwd_addr_n;
            r_fwd_data <= w_fwd_data_n;
            r_retired  <= w_retired_n;
        end
    end

    // Entry storage needs no reset: it is only observed while occupied.
    always_ff @(posedge clock) begin
        r_ent_addr <= w_ent_addr_n;
        r_ent_data <= w_ent_data_n;
    end

    assign wb_en     = r_wb_en;
    assign wb_addr   = r_wb_addr;
    assign wb_data   = r_wb_data;
    assign fwd_valid = r_wb_en;
    assign fwd_addr  = r_fwd_addr;
    assign fwd_data  = r_fwd_data;
    assign retired   = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Scoreboard bench for writeback_stage, ZERO_REG=0 and ZERO_REG=1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_writeback_stage;

    localparam int DW = 20;
    localparam int AW = 20;
    localparam int CW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          valid_in;
    logic          rf_ready;
    logic [DW-1:0] instruction;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] mem_data;
    logic [AW-1:0] address;

    logic          rdy0, en0, fv0, rdy1, en1, fv1;
    logic [AW-1:0] wa0, fa0, wa1, fa1;
    logic [DW-1:0] wd0, fd0, wd1, fd1;
    logic [CW-1:0] ret0, ret1;

    always #5 clock = ~clock;

    writeback_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .ZERO_REG(0)) u_dut0 (
        .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(rdy0),
        .instruction(instruction), .alu_result(alu_result), .mem_data(mem_data),
        .address(address), .rf_ready(rf_ready), .wb_en(en0), .wb_addr(wa0),
        .wb_data(wd0), .fwd_valid(fv0), .fwd_addr(fa0), .fwd_data(fd0),
        .retired(ret0));

    writeback_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .ZERO_REG(1)) u_dut1 (
        .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(rdy1),
        .instruction(instruction), .alu_result(alu_result), .mem_data(mem_data),
        .address(address), .rf_ready(rf_ready), .wb_en(en1), .wb_addr(wa1),
        .wb_data(wd1), .fwd_valid(fv1), .fwd_addr(fa1), .fwd_data(fd1),
        .retired(ret1));

    // Reference model: FIFO contents kept oldest-first, per DUT instance.
    ent_t          m_ent [2][2];
    int            m_n   [2];
    logic [CW-1:0] m_ret [2];
    ent_t          eq0[$];
    ent_t          eq1[$];
    bit            armed = 1'b0;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        int   n0;
        ent_t e;
        logic [3:0] op;
        n0 = m_n[d];
        if (n0 > 0 && rf_ready) begin
            m_ent[d][0] = m_ent[d][1];
            m_n[d]--;
            m_ret[d]++;
        end
        if (valid_in && n0 < 2) begin
            op = instruction[DW-1 -: 4];
            if (op == 4'hC || (d == 1 && address == '0)) begin
                m_ret[d]++;
            end else begin
                e.a = address;
                e.d = (op == 4'hD || op == 4'hF) ? mem_data : alu_result;
                m_ent[d][m_n[d]] = e;
                m_n[d]++;
                if (d == 0) eq0.push_back(e);
                else        eq1.push_back(e);
            end
        end
    endtask

    always @(posedge clock) begin
        if (reset) begin
            armed = 1'b1;
            for (int d = 0; d < 2; d++) begin
                m_n[d]   = 0;
                m_ret[d] = '0;
            end
            eq0.delete();
            eq1.delete();
        end else if (armed) begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic check_dut(input int d, input logic rdy, input logic en,
                             input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                             input logic fv, input logic [AW-1:0] fa,
                             input logic [DW-1:0] fd, input logic [CW-1:0] ret);
        ent_t e;
        ent_t t;
        int   n;
        n = m_n[d];
        t = (n > 0) ? m_ent[d][n-1] : '0;
        chk($sformatf("ready_in[%0d]", d), 64'(rdy), 64'(n < 2));
        chk($sformatf("wb_en[%0d]", d), 64'(en), 64'(n > 0));
        chk($sformatf("fwd_valid[%0d]", d), 64'(fv), 64'(n > 0));
        chk($sformatf("fwd_addr[%0d]", d), 64'(fa), 64'(t.a));
        chk($sformatf("fwd_data[%0d]", d), 64'(fd), 64'(t.d));
        chk($sformatf("retired[%0d]", d), 64'(ret), 64'(m_ret[d]));
        if (!en) begin
            chk($sformatf("wb_idle[%0d]", d), {wa, wd}, 64'(0));
        end else if (rf_ready && !reset) begin
            if ((d == 0 && eq0.size() == 0) || (d == 1 && eq1.size() == 0)) begin
                chk($sformatf("unexpected_write[%0d]", d), {wa, wd}, 64'(0));
            end else begin
                e = (d == 0) ? eq0.pop_front() : eq1.pop_front();
                chk($sformatf("write[%0d]", d), {wa, wd}, {e.a, e.d});
            end
        end
    endtask

    always @(negedge clock) begin
        if (armed) begin
            check_dut(0, rdy0, en0, wa0, wd0, fv0, fa0, fd0, ret0);
            check_dut(1, rdy1, en1, wa1, wd1, fv1, fa1, fd1, ret1);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] op, input logic [AW-1:0] a,
                          input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic rr);
        logic [DW-1:0] ins;
        ins          = DW'($urandom);
        ins[DW-1 -: 4] = op;
        valid_in     = v;
        instruction  = ins;
        address      = a;
        alu_result   = alu;
        mem_data     = mem;
        rf_ready     = rr;
    endtask

    // Hold an instruction until instance 0 accepts it, bounded.
    task automatic send(input logic [3:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic rr);
        int k;
        set_in(1'b1, op, a, alu, mem, rr);
        for (k = 0; k < 20 && m_n[0] >= 2; k++) cyc();
        if (k == 20) chk("send_timeout", 64'(m_n[0]), 64'(1));
        cyc();
        valid_in = 1'b0;
    endtask

    initial begin
        logic [3:0] ops [6];
        ops[0] = 4'hC; ops[1] = 4'hD; ops[2] = 4'hF;
        ops[3] = 4'h0; ops[4] = 4'h7; ops[5] = 4'hE;
        reset = 1'b1;
        set_in(1'b0, 4'h0, '0, '0, '0, 1'b0);
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        // Load, then store
        send(4'hD, 20'd5, 20'h11111, 20'h0ABCD, 1'b1);
        cyc(); cyc();
        send(4'hC, 20'd9, 20'h22222, 20'h33333, 1'b1);
        cyc();
        // Backpressure: addr 3 waits for space until rf_ready rises
        send(4'h1, 20'd1, 20'h00A01, 20'h0, 1'b0);
        send(4'h2, 20'd2, 20'h00A02, 20'h0, 1'b0);
        set_in(1'b1, 4'h3, 20'd3, 20'h00A03, 20'h0, 1'b0);
        cyc(); cyc();
        send(4'h3, 20'd3, 20'h00A03, 20'h0, 1'b1);
        cyc(); cyc(); cyc();
        // Simultaneous push and pop at occupancy 1
        send(4'h4, 20'd7, 20'h00B07, 20'h0, 1'b1);
        send(4'h5, 20'd8, 20'h00B08, 20'h0, 1'b1);
        cyc(); cyc();
        // Address 0 ALU op: written by instance 0, dropped by instance 1
        send(4'h6, 20'd0, 20'h00C00, 20'h0, 1'b1);
        cyc(); cyc();
        // Reset with two pending entries
        send(4'h0, 20'd11, 20'h00D11, 20'h0, 1'b0);
        send(4'h0, 20'd12, 20'h00D12, 20'h0, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        rf_ready = 1'b1;
        cyc(); cyc();
        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            set_in(($urandom % 4) != 0, ops[$urandom % 6], AW'($urandom % 4),
                   DW'($urandom), DW'($urandom), ($urandom % 3) != 0);
            cyc();
        end
        set_in(1'b0, 4'h0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 6; i++) cyc();
        chk("drain0", 64'(eq0.size()), 64'(0));
        chk("drain1", 64'(eq1.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
